// File: rtl/pipe_pkg.sv
// Shared types and helpers for the valid/ready pipeline stage registers.
// Stage payload structs are packed so callers can size DATA_W with $bits().
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pipe_state_e;

  localparam int unsigned OCC_W = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_pkt_t;

  typedef struct packed {
    logic [31:0] alu_y;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
  } ex_mem_pkt_t;

  typedef struct packed {
    logic [31:0] mem_data;
    logic [31:0] alu_y;
    logic [4:0]  rd;
    logic        regWrite;
    logic        memRead;
  } mem_wb_pkt_t;

  // Number of payloads held in a given state.
  function automatic logic [OCC_W-1:0] occ_of(input pipe_state_e s);
    logic [OCC_W-1:0] occ;
    case (s)
      PS_EMPTY: occ = 2'd0;
      PS_ONE:   occ = 2'd1;
      PS_TWO:   occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipe_sat_counter
  import pipe_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] cnt_r;
  logic [W-1:0] cnt_next_s;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_next_s = cnt_r;
    if (clr) begin
      cnt_next_s = {W{1'b0}};
    end else if (inc && (cnt_r != CNT_MAX)) begin
      cnt_next_s = cnt_r + W'(1'b1);
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {W{1'b0}};
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid pipeline register with flush and a stall-cycle counter.
// in_ready/out_valid/occupancy are registered decodes of the next state.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W     = 32,
  parameter int unsigned        CNT_W      = 16,
  parameter logic [DATA_W-1:0]  RESET_DATA = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        occupancy
);

  pipe_state_e       state_r;
  pipe_state_e       state_next_s;
  logic [DATA_W-1:0] main_r;
  logic [DATA_W-1:0] skid_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [1:0]        occupancy_r;

  logic              in_fire_s;
  logic              out_fire_s;
  logic              load_main_in_s;
  logic              load_main_skid_s;
  logic              load_skid_s;
  logic              stall_s;

  assign in_fire_s  = in_valid & in_ready_r;
  assign out_fire_s = out_valid_r & out_ready;
  assign stall_s    = out_valid_r & ~out_ready;

  // Next-state and payload-load decode; flush overrides every handshake.
  always_comb begin
    state_next_s     = state_r;
    load_main_in_s   = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    if (flush) begin
      state_next_s = PS_EMPTY;
    end else begin
      case (state_r)
        PS_EMPTY: begin
          if (in_fire_s) begin
            state_next_s   = PS_ONE;
            load_main_in_s = 1'b1;
          end else begin
            state_next_s = PS_EMPTY;
          end
        end
        PS_ONE: begin
          if (in_fire_s && out_fire_s) begin
            state_next_s   = PS_ONE;
            load_main_in_s = 1'b1;
          end else if (in_fire_s) begin
            state_next_s = PS_TWO;
            load_skid_s  = 1'b1;
          end else if (out_fire_s) begin
            state_next_s = PS_EMPTY;
          end else begin
            state_next_s = PS_ONE;
          end
        end
        PS_TWO: begin
          if (out_fire_s) begin
            state_next_s     = PS_ONE;
            load_main_skid_s = 1'b1;
          end else begin
            state_next_s = PS_TWO;
          end
        end
        default: begin
          state_next_s = PS_EMPTY;
        end
      endcase
    end
  end

  // State plus registered handshake outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= PS_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      occupancy_r <= 2'd0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s != PS_TWO);
      out_valid_r <= (state_next_s != PS_EMPTY);
      occupancy_r <= occ_of(state_next_s);
    end
  end

  // Payload registers; flush only clears validity, contents are kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_r <= RESET_DATA;
      skid_r <= RESET_DATA;
    end else begin
      if (load_main_in_s) begin
        main_r <= in_data;
      end else if (load_main_skid_s) begin
        main_r <= skid_r;
      end else begin
        main_r <= main_r;
      end
      if (load_skid_s) begin
        skid_r <= in_data;
      end else begin
        skid_r <= skid_r;
      end
    end
  end

  pipe_sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_s),
    .clr   (cnt_clr),
    .cnt   (stall_cnt)
  );

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;
  assign occupancy = occupancy_r;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed scenarios with literal expectations plus
// random traffic compared each cycle against a queue-based reference model.
module tb_pipe_skid_stage;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;
  localparam logic [DW-1:0] RST_D = 16'hDEAD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic          flush = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] stall_cnt;
  logic [1:0]    occupancy;

  int total = 0;
  int bad = 0;

  pipe_skid_stage #(
    .DATA_W     (DW),
    .CNT_W      (CW),
    .RESET_DATA (RST_D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .flush     (flush),
    .cnt_clr   (cnt_clr),
    .stall_cnt (stall_cnt),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two payloads and a saturating stall count.
  logic [DW-1:0] m_q[$];
  int            m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_cnt <= 0;
    end else begin
      m_cnt <= cnt_clr ? 0 :
               ((m_q.size() > 0 && !out_ready && m_cnt < 15) ? m_cnt + 1 : m_cnt);
      if (flush) begin
        m_q.delete();
      end else if (m_q.size() == 0) begin
        if (in_valid) m_q.push_back(in_data);
      end else if (m_q.size() == 1) begin
        if (out_ready) void'(m_q.pop_front());
        if (in_valid) m_q.push_back(in_data);
      end else begin
        if (out_ready) void'(m_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_in_ready", 32'(in_ready), 32'(m_q.size() < 2));
      chk("m_out_valid", 32'(out_valid), 32'(m_q.size() > 0));
      chk("m_occupancy", 32'(occupancy), 32'(m_q.size()));
      chk("m_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
      if (m_q.size() > 0) chk("m_out_data", 32'(out_data), 32'(m_q[0]));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_occ", 32'(occupancy), 32'h0);
    chk("rst_stall", 32'(stall_cnt), 32'h0);
    chk("rst_data", 32'(out_data), 32'hDEAD);

    // Streaming with out_ready high.
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'h0011; tick();
    chk("str_d0", 32'(out_data), 32'h11); chk("str_o0", 32'(occupancy), 32'h1);
    in_data = 16'h0022; tick();
    chk("str_d1", 32'(out_data), 32'h22); chk("str_o1", 32'(occupancy), 32'h1);
    in_data = 16'h0033; tick();
    chk("str_d2", 32'(out_data), 32'h33); chk("str_o2", 32'(occupancy), 32'h1);
    in_valid = 1'b0; tick();
    chk("str_empty", 32'(out_valid), 32'h0);

    // Backpressure.
    cnt_clr = 1'b1; out_ready = 1'b0; tick();
    cnt_clr = 1'b0;
    in_valid = 1'b1; in_data = 16'h00A1; tick();
    chk("bp_occ1", 32'(occupancy), 32'h1);
    in_data = 16'h00A2; tick();
    chk("bp_occ2", 32'(occupancy), 32'h2);
    chk("bp_rdy0", 32'(in_ready), 32'h0);
    chk("bp_head", 32'(out_data), 32'hA1);
    in_data = 16'h00A3; tick();
    chk("bp_hold", 32'(out_data), 32'hA1);
    out_ready = 1'b1; tick();
    chk("bp_a2", 32'(out_data), 32'hA2);
    chk("bp_rdy1", 32'(in_ready), 32'h1);
    tick();
    chk("bp_a3", 32'(out_data), 32'hA3);
    in_valid = 1'b0; tick();
    chk("bp_drained", 32'(out_valid), 32'h0);
    chk("bp_stall", 32'(stall_cnt), 32'h2);

    // Flush in TWO while an input is offered.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h00B1; tick();
    in_data = 16'h00B2; tick();
    chk("fl_occ2", 32'(occupancy), 32'h2);
    in_data = 16'h00B3; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 32'(out_valid), 32'h0);
    chk("fl_occ", 32'(occupancy), 32'h0);
    chk("fl_rdy", 32'(in_ready), 32'h1);
    out_ready = 1'b1; repeat (3) tick();
    chk("fl_stays", 32'(out_valid), 32'h0);

    // Counter saturation and clear priority.
    out_ready = 1'b0; cnt_clr = 1'b1; tick();
    cnt_clr = 1'b0;
    in_valid = 1'b1; in_data = 16'h00C1; tick();
    in_valid = 1'b0;
    repeat (20) tick();
    chk("sat_15", 32'(stall_cnt), 32'hF);
    cnt_clr = 1'b1; tick();
    chk("clr_0", 32'(stall_cnt), 32'h0);
    cnt_clr = 1'b0; tick();
    chk("clr_1", 32'(stall_cnt), 32'h1);

    // Async reset while holding two entries.
    in_valid = 1'b1; in_data = 16'h00D1; tick();
    in_valid = 1'b0;
    chk("ar_occ2", 32'(occupancy), 32'h2);
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk("ar_valid", 32'(out_valid), 32'h0);
    chk("ar_rdy", 32'(in_ready), 32'h1);
    chk("ar_occ", 32'(occupancy), 32'h0);
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'h00E1; tick();
    chk("ar_accept_v", 32'(out_valid), 32'h1);
    chk("ar_accept_d", 32'(out_data), 32'hE1);
    in_valid = 1'b0; tick();

    // Random traffic checked by the model every cycle.
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 16'($urandom);
      out_ready = (i % 100 < 50) ? 1'($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 3) == 0);
      flush     = 1'($urandom_range(0, 24) == 0);
      cnt_clr   = 1'($urandom_range(0, 39) == 0);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised successor to the fixed-field pipeline register between the memory and writeback stages. It is usable at any stage boundary: IF/ID, ID/EX, EX/MEM or MEM/WB.
- Carries an opaque payload of DATA_W bits with a valid/ready handshake on both sides.
- A 2-entry skid buffer keeps in_ready a pure register output, so backpressure never forms a combinational path through the stage.
- Adds synchronous flush (bubble injection) and a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_W, 32, payload width in bits (pack mem_data/alu_y/rd/regWrite/memRead or any stage bundle).
- CNT_W, 16, stall counter width.
- RESET_DATA, '0, value loaded into both payload registers on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream has a payload.
- in_data  input  DATA_W  upstream payload.
- in_ready  output  1  stage can accept; registered.
- out_valid  output  1  stage holds a payload for downstream.
- out_data  output  DATA_W  head payload.
- out_ready  input  1  downstream accepts.
- flush  input  1  synchronous kill of all held and incoming payloads.
- cnt_clr  input  1  synchronous clear of stall_cnt.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.
- occupancy  output  2  held entries, 0..2.

Behaviour:
- One clock domain. Reset is asynchronous, active-low (rst_n), on clk.
- Reset values:
  - state=EMPTY, out_valid=0, in_ready=1.
  - main and skid payload registers = RESET_DATA.
  - stall_cnt=0, occupancy=0.
- Handshakes:
  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
  - in_data is sampled only on in_fire.
  - out_data is stable while out_valid=1 and out_ready=0.
- Registers: main (drives out_data) and skid. States are EMPTY (0 held), ONE (main valid) and TWO (main and skid valid).
- Outputs derived from state only:
  - in_ready = (state!=TWO).
  - out_valid = (state!=EMPTY).
  - occupancy = 0/1/2 for EMPTY/ONE/TWO.
- Transitions when flush=0:
  - EMPTY & in_fire -> ONE, main<=in_data.
  - ONE & in_fire & out_fire -> ONE, main<=in_data.
  - ONE & in_fire & !out_fire -> TWO, skid<=in_data.
  - ONE & !in_fire & out_fire -> EMPTY.
  - TWO & out_fire -> ONE, main<=skid (in_ready=0, so no input is taken).
  - All other cases hold state.
- Latency: 1 cycle from in_fire in EMPTY to out_valid=1. Throughput is 1 payload per cycle when out_ready is held high.
- Ordering: strictly FIFO; skid content always leaves after main.
- flush=1:
  - Next state is EMPTY regardless of current state or handshakes.
  - An in_fire in the same cycle is dropped. in_ready may be 1 that cycle and upstream treats the payload as consumed-and-killed.
  - An out_fire in the same cycle still completes downstream.
  - Payload registers keep their values; only valid is cleared.
- stall_cnt:
  - Increments when out_valid & !out_ready.
  - Saturates at all ones with no wrap.
  - cnt_clr has priority and loads 0. cnt_clr and a stall in the same cycle give 0.
  - Not affected by flush.
- Reset asserted mid-transfer: both entries are lost immediately, and in_ready returns to 1 asynchronously.
- Never: out_valid deasserting without out_fire or flush; out_data changing while stalled.

Decomposition:
- Shared package pipe_pkg:
  - typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_TWO} pipe_state_e.
  - Function occ_of(pipe_state_e).
  - Stage payload structs, e.g. mem_wb_pkt_t {mem_data, alu_y, rd, regWrite, memRead}, so callers pass $bits(mem_wb_pkt_t) as DATA_W.
- One natural sub-module: pipe_sat_counter (parameter W; inputs inc, clr; output cnt). It is reused by other stages' perf counters.

Test Plan:
- Reset then idle: after rst_n rises -> in_ready=1, out_valid=0, occupancy=0, stall_cnt=0, out_data=RESET_DATA.
- Streaming: out_ready=1, send 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 on the next three cycles, occupancy never exceeds 1.
- Backpressure: out_ready=0, send 0xA1,0xA2 -> occupancy=2, in_ready=0. A further 0xA3 is held upstream. Raise out_ready -> outputs 0xA1,0xA2,0xA3 in order; stall_cnt equals the stalled cycles.
- Flush in TWO with in_valid=1 (0xB3): next cycle out_valid=0, occupancy=0, in_ready=1. 0xB1, 0xB2 and 0xB3 never appear downstream.
- Counter saturation with CNT_W=4: hold a stall for 20 cycles -> stall_cnt=15. Then pulse cnt_clr with the stall still active -> stall_cnt=0, then 1 the next cycle.
- Async reset in TWO: drop rst_n mid-cycle -> out_valid=0 and in_ready=1 before the next clk edge; after release the stage accepts normally.
